card_board_ctrl: RTL and testbench

Board-side responder to the gameplay state machine in the memory-match design. It holds the 16-entry card board (2-bit status, 4-bit value) written through the gameplay write port (WriteEnable/dataLoc/dataOut). It moves a cursor over the 4x4 grid from push-button inputs and drives Select, CardSelectLoc and CardSelectData back to the gameplay SM. It also provides a registered read port for the VGA renderer.

---
 rtl/card_board_ctrl_if.sv | 23 ++
 rtl/card_board_ctrl.sv | 174 +++++++++++++++++
 tb/tb_card_board_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_board_ctrl_if.sv
// Gameplay-side bundle for the card board: board write port plus the
// card-select handshake returned to the gameplay state machine.
interface card_board_ctrl_if;
    logic       WriteEnable;
    logic [3:0] dataLoc;
    logic [5:0] dataOut;
    logic       SelEnable;
    logic       Select;
    logic [3:0] CardSelectLoc;
    logic [5:0] CardSelectData;

    // gameplay state machine side
    modport master (
        output WriteEnable, dataLoc, dataOut, SelEnable,
        input  Select, CardSelectLoc, CardSelectData
    );

    // card board side
    modport slave (
        input  WriteEnable, dataLoc, dataOut, SelEnable,
        output Select, CardSelectLoc, CardSelectData
    );
endinterface

// File: rtl/card_board_ctrl.sv
// Card board responder: 16-entry board store, button synchronizers with
// edge detect, 4x4 cursor, select/hold/reject state machine and a
// registered display read port.
module card_board_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_HOLD    = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    card_board_ctrl_if.slave    gp,
    input  logic                BtnU,
    input  logic                BtnD,
    input  logic                BtnL,
    input  logic                BtnR,
    input  logic                BtnC,
    output logic [3:0]          Cursor,
    input  logic [3:0]          ReadLoc,
    output logic [5:0]          ReadData
);

    localparam int unsigned HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REJECT = 2'd2
    } state_t;

    // button bit order: 4=U 3=D 2=L 1=R 0=C
    logic [4:0]    btn_raw;
    logic [4:0]    sync_q [SYNC_STAGES];
    logic [4:0]    sync_d [SYNC_STAGES];
    logic [4:0]    edge_q, edge_d;
    logic [4:0]    btn_lvl;
    logic [4:0]    pulse;

    logic [5:0]    board_q [16];
    logic [5:0]    board_d [16];
    logic [5:0]    read_q, read_d;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [3:0]    loc_q, loc_d;
    logic [5:0]    dat_q, dat_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    cursor_q, cursor_d;
    logic [5:0]    cur_entry;

    assign btn_raw   = {BtnU, BtnD, BtnL, BtnR, BtnC};
    assign btn_lvl   = sync_q[SYNC_STAGES-1];
    assign pulse     = btn_lvl & ~edge_q;
    assign cur_entry = board_q[cursor_q];

    // synchronizer shift chain and previous-level register for edge detect
    always_comb begin
        sync_d[0] = btn_raw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        edge_d = btn_lvl;
    end

    // synchronizer and edge registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            edge_q <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            edge_q <= edge_d;
        end
    end

    // board write (never gated by state) and display read of the old contents
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            board_d[i] = board_q[i];
        end
        if (gp.WriteEnable) begin
            board_d[gp.dataLoc] = gp.dataOut;
        end
        read_d = board_q[ReadLoc];
    end

    // board store and read data register; reset marks every card removed
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < 16; i++) begin
                board_q[i] <= 6'b10_0000;
            end
            read_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                board_q[i] <= board_d[i];
            end
            read_q <= read_d;
        end
    end

    // next state: cursor moves and C-press handling in IDLE, hold timing in HOLD
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        loc_d    = loc_q;
        dat_d    = dat_q;
        hold_d   = hold_q;
        cursor_d = cursor_q;
        case (state_q)
            IDLE: begin
                // 2-bit row/col arithmetic wraps on its own
                if (pulse[4])      cursor_d[3:2] = cursor_q[3:2] - 2'd1;
                else if (pulse[3]) cursor_d[3:2] = cursor_q[3:2] + 2'd1;
                else if (pulse[2]) cursor_d[1:0] = cursor_q[1:0] - 2'd1;
                else if (pulse[1]) cursor_d[1:0] = cursor_q[1:0] + 2'd1;
                if (pulse[0] && gp.SelEnable) begin
                    if (cur_entry[5:4] == 2'b01) begin
                        loc_d   = cursor_q;
                        dat_d   = cur_entry;
                        sel_d   = 1'b1;
                        hold_d  = HW'(MIN_HOLD - 1);
                        state_d = HOLD;
                    end else begin
                        state_d = REJECT;
                    end
                end
            end
            HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (!btn_lvl[0]) begin
                    sel_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            REJECT: begin
                state_d = IDLE;
            end
            default: begin
                sel_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // state machine and select registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            loc_q    <= '0;
            dat_q    <= '0;
            hold_q   <= '0;
            cursor_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            loc_q    <= loc_d;
            dat_q    <= dat_d;
            hold_q   <= hold_d;
            cursor_q <= cursor_d;
        end
    end

    assign gp.Select         = sel_q;
    assign gp.CardSelectLoc  = (state_q == IDLE) ? cursor_q  : loc_q;
    assign gp.CardSelectData = (state_q == IDLE) ? cur_entry : dat_q;
    assign Cursor            = cursor_q;
    assign ReadData          = read_q;

endmodule

// File: tb/tb_card_board_ctrl.sv
// Self-checking bench for card_board_ctrl: scoreboard queues for the read
// port and for select events, one task per scenario.
module tb_card_board_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       BtnU, BtnD, BtnL, BtnR, BtnC;
    logic [3:0] Cursor;
    logic [3:0] ReadLoc;
    logic [5:0] ReadData;

    card_board_ctrl_if gp ();

    card_board_ctrl #(.SYNC_STAGES(2), .MIN_HOLD(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .gp       (gp.slave),
        .BtnU     (BtnU),
        .BtnD     (BtnD),
        .BtnL     (BtnL),
        .BtnR     (BtnR),
        .BtnC     (BtnC),
        .Cursor   (Cursor),
        .ReadLoc  (ReadLoc),
        .ReadData (ReadData)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    logic [5:0] model [16];
    logic [5:0] rd_sb [$];
    logic [9:0] sel_sb [$];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] loc, input logic [5:0] data);
        gp.WriteEnable = 1'b1;
        gp.dataLoc     = loc;
        gp.dataOut     = data;
        tick();
        model[loc]     = data;
        gp.WriteEnable = 1'b0;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            4: BtnU = v;
            3: BtnD = v;
            2: BtnL = v;
            1: BtnR = v;
            default: BtnC = v;
        endcase
    endtask

    // one-cycle press, then enough cycles for sync + edge + update
    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        tick();
        set_btn(idx, 1'b0);
        repeat (5) tick();
    endtask

    task automatic chk_cursor(input string name, input logic [3:0] exp);
        total++;
        if (Cursor !== exp) begin
            bad++;
            $display("FAIL %s: Cursor=%0d expected=%0d", name, Cursor, exp);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        total++;
        if (gp.Select !== 1'b0) begin
            bad++; $display("FAIL reset_select: got=%b exp=0", gp.Select);
        end
        chk_cursor("reset_cursor", 4'd0);
        total++;
        if (gp.CardSelectLoc !== 4'd0) begin
            bad++; $display("FAIL reset_loc: got=%0d exp=0", gp.CardSelectLoc);
        end
        total++;
        if (ReadData !== 6'h20) begin
            bad++; $display("FAIL reset_readdata: got=%h exp=20", ReadData);
        end
        for (int i = 0; i < 16; i++) begin
            ReadLoc = 4'(i);
            rd_sb.push_back(model[i]);
            tick();
            begin
                logic [5:0] e;
                e = rd_sb.pop_front();
                total++;
                if (ReadData !== e) begin
                    bad++; $display("FAIL reset_read[%0d]: got=%h exp=%h", i, ReadData, e);
                end
            end
        end
    endtask

    task automatic test_read_collision();
        logic [5:0] e;
        ReadLoc = 4'd5;
        rd_sb.push_back(model[5]);
        wr(4'd5, 6'b01_0011);
        e = rd_sb.pop_front();
        total++;
        if (ReadData !== e) begin
            bad++; $display("FAIL collide_old: got=%h exp=%h", ReadData, e);
        end
        rd_sb.push_back(model[5]);
        tick();
        e = rd_sb.pop_front();
        total++;
        if (ReadData !== e) begin
            bad++; $display("FAIL collide_new: got=%h exp=%h", ReadData, e);
        end
    endtask

    task automatic test_cursor();
        press(2); chk_cursor("cursor_L_wrap", 4'd3);
        press(4); chk_cursor("cursor_U_wrap", 4'd15);
        press(1); chk_cursor("cursor_R_wrap", 4'd12);
        BtnU = 1'b1; BtnR = 1'b1;
        tick();
        BtnU = 1'b0; BtnR = 1'b0;
        repeat (5) tick();
        chk_cursor("cursor_U_over_R", 4'd8);
        press(4); press(1);
        chk_cursor("cursor_to_5", 4'd5);
    endtask

    task automatic test_select_hold();
        int t;
        logic rose;
        logic [9:0] e;
        gp.SelEnable = 1'b1;
        sel_sb.push_back({4'd5, model[5]});
        BtnC = 1'b1;
        t = 0;
        rose = 1'b0;
        while (!rose && t < 8) begin
            tick(); t++;
            if (gp.Select === 1'b1) rose = 1'b1;
        end
        total++;
        if (!rose) begin
            bad++; $display("FAIL hold_rise: Select never rose within %0d cycles", t);
        end else begin
            e = sel_sb.pop_front();
            total++;
            if ({gp.CardSelectLoc, gp.CardSelectData} !== e) begin
                bad++; $display("FAIL hold_latch: got=%0d/%h exp=%0d/%h",
                                gp.CardSelectLoc, gp.CardSelectData, e[9:6], e[5:0]);
            end
            wr(4'd5, 6'h03); t++;
            total++;
            if (gp.CardSelectData !== 6'h13 || gp.Select !== 1'b1) begin
                bad++; $display("FAIL hold_frozen: sel=%b data=%h exp sel=1 data=13",
                                gp.Select, gp.CardSelectData);
            end
            while (t < 10) begin tick(); t++; end
            BtnC = 1'b0;
            tick();
            total++;
            if (gp.Select !== 1'b1) begin
                bad++; $display("FAIL hold_release1: got=%b exp=1", gp.Select);
            end
            tick();
            total++;
            if (gp.Select !== 1'b1) begin
                bad++; $display("FAIL hold_release2: got=%b exp=1", gp.Select);
            end
            tick();
            total++;
            if (gp.Select !== 1'b0) begin
                bad++; $display("FAIL hold_release3: got=%b exp=0", gp.Select);
            end
        end
        BtnC = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_min_hold();
        int high;
        logic seen;
        logic [9:0] e;
        wr(4'd5, 6'h13);
        sel_sb.push_back({4'd5, model[5]});
        BtnC = 1'b1;
        tick();
        BtnC = 1'b0;
        high = 0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            BtnL = 1'b0;
            if (gp.Select === 1'b1) begin
                high++;
                if (!seen) begin
                    seen = 1'b1;
                    BtnL = 1'b1;
                    e = sel_sb.pop_front();
                    total++;
                    if ({gp.CardSelectLoc, gp.CardSelectData} !== e) begin
                        bad++; $display("FAIL minhold_latch: got=%0d/%h exp=%0d/%h",
                                        gp.CardSelectLoc, gp.CardSelectData, e[9:6], e[5:0]);
                    end
                end
            end
        end
        BtnL = 1'b0;
        total++;
        if (high != 4) begin
            bad++; $display("FAIL minhold_len: high_cycles=%0d exp=4", high);
        end
        chk_cursor("minhold_cursor_frozen", 4'd5);
    endtask

    task automatic test_reject();
        int high, rej;
        wr(4'd2, 6'h25);
        press(4); press(1);
        chk_cursor("reject_cursor", 4'd2);
        gp.SelEnable = 1'b1;
        BtnC = 1'b1; tick(); BtnC = 1'b0;
        high = 0; rej = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (gp.Select === 1'b1) high++;
            if (dut.state_q == 2'd2) rej++;
        end
        total++;
        if (high != 0 || rej != 1) begin
            bad++; $display("FAIL reject: select_cycles=%0d reject_cycles=%0d exp 0/1", high, rej);
        end
        press(3); press(2);
        chk_cursor("nosel_cursor", 4'd5);
        gp.SelEnable = 1'b0;
        BtnC = 1'b1; tick(); BtnC = 1'b0;
        high = 0; rej = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (gp.Select === 1'b1) high++;
            if (dut.state_q != 2'd0) rej++;
        end
        total++;
        if (high != 0 || rej != 0) begin
            bad++; $display("FAIL sel_disabled: select_cycles=%0d non_idle=%0d exp 0/0", high, rej);
        end
    endtask

    task automatic test_reset_in_hold();
        int t;
        logic [5:0] e;
        logic [9:0] s;
        gp.SelEnable = 1'b1;
        sel_sb.push_back({4'd5, model[5]});
        BtnC = 1'b1; tick(); BtnC = 1'b0;
        t = 0;
        while (gp.Select !== 1'b1 && t < 8) begin tick(); t++; end
        total++;
        if (gp.Select !== 1'b1) begin
            bad++; $display("FAIL rst_hold_rise: Select never rose");
        end else begin
            s = sel_sb.pop_front();
            total++;
            if (gp.CardSelectLoc !== s[9:6]) begin
                bad++; $display("FAIL rst_hold_loc: got=%0d exp=%0d", gp.CardSelectLoc, s[9:6]);
            end
        end
        #1 Reset = 1'b1;
        #1;
        total++;
        if (gp.Select !== 1'b0 || dut.state_q != 2'd0 || Cursor !== 4'd0) begin
            bad++; $display("FAIL rst_async: sel=%b state=%0d cursor=%0d exp 0/0/0",
                            gp.Select, dut.state_q, Cursor);
        end
        repeat (2) tick();
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 6'h20;
        ReadLoc = 4'd5;
        rd_sb.push_back(model[5]);
        tick();
        e = rd_sb.pop_front();
        total++;
        if (ReadData !== e) begin
            bad++; $display("FAIL rst_board_cleared: got=%h exp=%h", ReadData, e);
        end
    endtask

    initial begin
        Reset = 1'b1;
        BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0; BtnC = 1'b0;
        ReadLoc = 4'd0;
        gp.WriteEnable = 1'b0;
        gp.dataLoc = 4'd0;
        gp.dataOut = 6'd0;
        gp.SelEnable = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 6'h20;

        test_reset();
        test_read_collision();
        test_cursor();
        test_select_hold();
        test_min_hold();
        test_reject();
        test_reset_in_hold();

        total++;
        if (sel_sb.size() != 0 || rd_sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: sel_left=%0d rd_left=%0d exp 0/0",
                            sel_sb.size(), rd_sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
